// File: rtl/sine_sequencer_pkg.sv
// Shared constants and types for the quarter-wave sine sequencer and its phase folder.
package sine_sequencer_pkg;

  localparam int DEFAULT_DATA_W  = 24;
  localparam int DEFAULT_ADDR_W  = 7;
  localparam int DEFAULT_PHASE_W = 9;
  localparam int DEFAULT_BURST_W = 16;

  localparam int QUARTER = 90;
  localparam int PERIOD  = 4 * QUARTER;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_e;

endpackage

// File: rtl/sine_phase_fold.sv
// Maps a phase in 0..PERIOD-1 onto a quarter-wave LUT address plus a negate flag.
module sine_phase_fold
  import sine_sequencer_pkg::*;
#(
  parameter int PHASE_W = DEFAULT_PHASE_W,
  parameter int ADDR_W  = DEFAULT_ADDR_W
) (
  input  logic [PHASE_W-1:0] phase,
  output logic [ADDR_W-1:0]  addr,
  output logic               neg
);

  localparam logic [PHASE_W-1:0] Q1 = PHASE_W'(QUARTER);
  localparam logic [PHASE_W-1:0] Q2 = PHASE_W'(2 * QUARTER);
  localparam logic [PHASE_W-1:0] Q3 = PHASE_W'(3 * QUARTER);

  logic [PHASE_W-1:0] r;
  logic               mirror;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    r      = phase;
    mirror = 1'b0;
    neg    = 1'b0;
    if (phase < Q1) begin
      r = phase;
    end else if (phase < Q2) begin
      r      = phase - Q1;
      mirror = 1'b1;
    end else if (phase < Q3) begin
      r   = phase - Q2;
      neg = 1'b1;
    end else begin
      r      = phase - Q3;
      mirror = 1'b1;
      neg    = 1'b1;
    end
    addr = mirror ? ADDR_W'(Q1 - r) : ADDR_W'(r);
  end

endmodule

// File: rtl/sine_sequencer.sv
// Full-period sine stream generator driving an external quarter-wave LUT with start/stop/burst control.
module sine_sequencer
  import sine_sequencer_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int PHASE_W = DEFAULT_PHASE_W,
  parameter int BURST_W = DEFAULT_BURST_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] step,
  input  logic [BURST_W-1:0] burst_len,
  output logic [ADDR_W-1:0]  lut_addr,
  input  logic [DATA_W-1:0]  lut_data,
  input  logic               ready,
  output logic               valid,
  output logic [DATA_W-1:0]  out,
  output logic               busy,
  output logic               done
);

  localparam logic [PHASE_W-1:0] STEP_MAX   = PHASE_W'(PERIOD - 1);
  localparam logic [PHASE_W:0]   PERIOD_EXT = (PHASE_W + 1)'(PERIOD);

  state_e state, state_nx;

  logic [PHASE_W-1:0] phase, step_q, step_clamped, issue_phase, issue_step, phase_next;
  logic [PHASE_W:0]   phase_sum;
  logic [BURST_W-1:0] burst_q, issued;
  logic               advance, burst_hit, issue, drained;
  logic [ADDR_W-1:0]  fold_addr;
  logic               fold_neg;

  // Pipeline: stage 0 drives the LUT address; stage 1 waits for the LUT word; then out/valid.
  logic               v0, s0_neg;
  logic               v1, s1_neg, s1_fresh;
  logic [DATA_W-1:0]  s1_data, s1_word;

  assign advance      = !valid || ready;
  assign burst_hit    = (burst_q != '0) && (issued == burst_q);
  assign step_clamped = (step > STEP_MAX) ? STEP_MAX : step;
  assign drained      = !v0 && !v1 && (!valid || ready);

  always_comb begin
    issue = 1'b0;
    if (advance) begin
      unique case (state)
        IDLE:    issue = start;
        RUN:     issue = !stop && !burst_hit;
        default: issue = 1'b0;
      endcase
    end
  end

  // The start sample always sits at phase 0 and uses the freshly presented step.
  assign issue_phase = (state == IDLE) ? '0 : phase;
  assign issue_step  = (state == IDLE) ? step_clamped : step_q;
  assign phase_sum   = {1'b0, issue_phase} + {1'b0, issue_step};
  assign phase_next  = (phase_sum >= PERIOD_EXT) ? PHASE_W'(phase_sum - PERIOD_EXT)
                                                 : PHASE_W'(phase_sum);

  sine_phase_fold #(
    .PHASE_W(PHASE_W),
    .ADDR_W (ADDR_W)
  ) u_fold (
    .phase(issue_phase),
    .addr (fold_addr),
    .neg  (fold_neg)
  );

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so every register sees pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (stop || burst_hit) state_nx = FLUSH;
      FLUSH:   if (drained) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase   <= '0;
      step_q  <= '0;
      burst_q <= '0;
      issued  <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == FLUSH) && drained;
      if (state == IDLE && start) begin
        step_q  <= step_clamped;
        burst_q <= burst_len;
      end
      if (issue) begin
        phase  <= phase_next;
        issued <= (state == IDLE) ? BURST_W'(1) : issued + BURST_W'(1);
      end
    end
  end

  // The LUT re-reads lut_addr every cycle, so a stalled stage-1 word is kept locally.
  assign s1_word = s1_fresh ? lut_data : s1_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v0       <= 1'b0;
      s0_neg   <= 1'b0;
      lut_addr <= '0;
      v1       <= 1'b0;
      s1_neg   <= 1'b0;
      s1_fresh <= 1'b0;
      s1_data  <= '0;
      valid    <= 1'b0;
      out      <= '0;
    end else if (advance) begin
      v0 <= issue;
      if (issue) begin
        lut_addr <= fold_addr;
        s0_neg   <= fold_neg;
      end
      v1       <= v0;
      s1_neg   <= s0_neg;
      s1_fresh <= 1'b1;
      valid    <= v1;
      if (v1) out <= s1_neg ? (~s1_word + DATA_W'(1)) : s1_word;
    end else begin
      s1_data  <= s1_word;
      s1_fresh <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sine_sequencer.sv
// Randomized bench for sine_sequencer against a phase-arithmetic reference model and a behavioural LUT.
module tb_sine_sequencer;
  import sine_sequencer_pkg::*;

  localparam int DATA_W  = DEFAULT_DATA_W;
  localparam int ADDR_W  = DEFAULT_ADDR_W;
  localparam int PHASE_W = DEFAULT_PHASE_W;
  localparam int BURST_W = DEFAULT_BURST_W;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               ready = 1'b1;
  logic [PHASE_W-1:0] step = '0;
  logic [BURST_W-1:0] burst_len = '0;
  logic [ADDR_W-1:0]  lut_addr;
  logic [DATA_W-1:0]  lut_data = '0;
  logic               valid, busy, done;
  logic [DATA_W-1:0]  out;

  logic [DATA_W-1:0]  lut_mem [0:127];
  logic [DATA_W-1:0]  got [$];
  int total = 0;
  int bad   = 0;

  sine_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .step     (step),
    .burst_len(burst_len),
    .lut_addr (lut_addr),
    .lut_data (lut_data),
    .ready    (ready),
    .valid    (valid),
    .out      (out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) lut_data <= lut_mem[lut_addr];

  always @(negedge clk) if (valid === 1'b1 && ready === 1'b1) got.push_back(out);

  // Sample k of a run sits at (k*step) mod 360 degrees; the quarter table is mirrored by symmetry.
  function automatic logic [DATA_W-1:0] model(int k, int st);
    int s, deg;
    s   = (st > 359) ? 359 : st;
    deg = (k * s) % 360;
    if (deg < 90)       return lut_mem[deg];
    else if (deg < 180) return lut_mem[180 - deg];
    else if (deg < 270) return DATA_W'(-int'(lut_mem[deg - 180]));
    else                return DATA_W'(-int'(lut_mem[360 - deg]));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(int st, int bl);
    start     = 1'b1;
    step      = PHASE_W'(st);
    burst_len = BURST_W'(bl);
    tick();
    start     = 1'b0;
    step      = PHASE_W'($urandom);
    burst_len = BURST_W'($urandom);
  endtask

  task automatic wait_count(string name, int n);
    int c = 0;
    while (got.size() < n && c < 5000) begin
      tick();
      c++;
    end
    total++;
    if (got.size() < n) begin
      bad++;
      $display("FAIL %s: collected %0d samples, required %0d", name, got.size(), n);
    end
  endtask

  task automatic wait_done(string name, bit rnd_ready);
    bit seen = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      if (rnd_ready) ready = 1'($urandom_range(0, 1));
    end
    ready = 1'b1;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s done: never pulsed, required 1", name);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy at done: got %b, required 0", name, busy);
    end
    tick();
    total++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL %s after done: done=%b valid=%b, required 0 0", name, done, valid);
    end
  endtask

  task automatic check_stream(string name, int st, int exp_n);
    if (exp_n >= 0) begin
      total++;
      if (got.size() != exp_n) begin
        bad++;
        $display("FAIL %s count: got %0d, required %0d", name, got.size(), exp_n);
      end
    end
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== model(i, st)) begin
        bad++;
        $display("FAIL %s sample %0d: got %h, required %h", name, i, got[i], model(i, st));
      end
    end
    got.delete();
  endtask

  task automatic finish_run(string name, int st);
    ready = 1'b1;
    if (busy) begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
    end
    wait_done(name, 1'b0);
    check_stream(name, st, -1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    total++;
    if (valid !== 1'b0 || out !== '0 || busy !== 1'b0 || done !== 1'b0 || lut_addr !== '0) begin
      bad++;
      $display("FAIL reset state: valid=%b out=%h busy=%b done=%b addr=%0d, required all 0",
               valid, out, busy, done, lut_addr);
    end
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_continuous_step1();
    pulse_start(1, 0);
    wait_count("step1", 362);
    finish_run("step1", 1);
  endtask

  task automatic test_step90_latency();
    ready = 1'b1;
    pulse_start(90, 0);
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL latency edge1: valid=%b, required 0", valid);
    end
    tick();
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL latency edge2: valid=%b, required 0", valid);
    end
    tick();
    total++;
    if (valid !== 1'b1 || out !== lut_mem[0]) begin
      bad++;
      $display("FAIL latency edge3: valid=%b out=%h, required 1 %h", valid, out, lut_mem[0]);
    end
    wait_count("step90", 9);
    finish_run("step90", 90);
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] held;
    logic [ADDR_W-1:0] held_addr;
    pulse_start(30, 0);
    wait_count("bp", 3);
    ready     = 1'b0;
    held      = out;
    held_addr = lut_addr;
    total++;
    if (valid !== 1'b1) begin
      bad++;
      $display("FAIL bp stall entry: valid=%b, required 1", valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (valid !== 1'b1 || out !== held || lut_addr !== held_addr) begin
        bad++;
        $display("FAIL bp hold %0d: valid=%b out=%h addr=%0d, required 1 %h %0d",
                 i, valid, out, lut_addr, held, held_addr);
      end
    end
    for (int i = 0; i < 60; i++) begin
      ready = 1'($urandom_range(0, 1));
      tick();
    end
    finish_run("bp", 30);
  endtask

  task automatic test_burst(string name, int st, int bl, bit rnd_ready);
    pulse_start(st, bl);
    wait_done(name, rnd_ready);
    repeat (3) tick();
    total++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle: valid=%b busy=%b, required 0 0", name, valid, busy);
    end
    check_stream(name, st, bl);
  endtask

  task automatic test_stop_flush();
    int st;
    st    = int'($urandom_range(1, 359));
    ready = 1'b1;
    pulse_start(st, 0);
    tick();
    stop = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b1;
    step  = PHASE_W'(7);
    tick();
    start = 1'b0;
    wait_done("stop", 1'b0);
    repeat (4) tick();
    total++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL stop start-ignored: busy=%b valid=%b, required 0 0", busy, valid);
    end
    check_stream("stop", st, 2);
  endtask

  task automatic test_clamp_reset();
    pulse_start(400, 0);
    wait_count("clamp", 6);
    total++;
    if (valid !== 1'b1) begin
      bad++;
      $display("FAIL clamp running: valid=%b, required 1", valid);
    end
    reset = 1'b0;
    #1;
    total++;
    if (valid !== 1'b0 || out !== '0 || busy !== 1'b0 || lut_addr !== '0) begin
      bad++;
      $display("FAIL async reset: valid=%b out=%h busy=%b addr=%0d, required 0 0 0 0",
               valid, out, busy, lut_addr);
    end
    check_stream("clamp", 400, -1);
    tick();
    reset = 1'b1;
    repeat (6) tick();
    total++;
    if (valid !== 1'b0 || busy !== 1'b0 || got.size() != 0) begin
      bad++;
      $display("FAIL reset release: valid=%b busy=%b samples=%0d, required 0 0 0",
               valid, busy, got.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++)
      lut_mem[i] = (i <= QUARTER) ? DATA_W'($urandom_range(1, 32'h7F_FFFF)) : '0;
    #1;
    test_reset();
    test_continuous_step1();
    test_step90_latency();
    test_backpressure();
    test_burst("burst45", 45, 4, 1'b0);
    test_stop_flush();
    test_clamp_reset();
    for (int i = 0; i < 4; i++)
      test_burst("rnd_burst", int'($urandom_range(0, 500)), int'($urandom_range(1, 12)), 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
